quadrature_decoder: RTL and testbench

Upstream front end for the up/down counter. Decodes a two-channel quadrature encoder (ChannelA/ChannelB) into a single-cycle StepPulse plus a UpDownMode direction level. These outputs wire directly to the counter's clock-enable/step and UpDownMode inputs. It also synchronises and glitch-filters the raw inputs, and flags illegal Gray transitions.

---
 rtl/quadrature_decoder_pkg.sv | 40 ++++
 rtl/quadrature_decoder_filter.sv | 71 +++++++
 rtl/quadrature_decoder.sv | 108 ++++++++++
 tb/tb_quadrature_decoder.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/quadrature_decoder_pkg.sv
// Shared encodings for the quadrature decoder: channel states, step modes, direction.
package quadrature_pkg;

  // Filtered channel pair, encoded as {A,B}.
  typedef enum logic [1:0] {
    ST_00 = 2'b00,
    ST_01 = 2'b01,
    ST_10 = 2'b10,
    ST_11 = 2'b11
  } ab_state_t;

  localparam int unsigned STEP_MODE_X1 = 1;
  localparam int unsigned STEP_MODE_X2 = 2;
  localparam int unsigned STEP_MODE_X4 = 4;

  // Matches the counter's UpDownMode input.
  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  // Up sequence: 00 -> 10 -> 11 -> 01 -> 00.
  function automatic ab_state_t next_up(input ab_state_t s);
    case (s)
      ST_00:   return ST_10;
      ST_10:   return ST_11;
      ST_11:   return ST_01;
      default: return ST_00;
    endcase
  endfunction

  // Down sequence is the reverse of the up sequence.
  function automatic ab_state_t next_down(input ab_state_t s);
    case (s)
      ST_00:   return ST_01;
      ST_01:   return ST_11;
      ST_11:   return ST_10;
      default: return ST_00;
    endcase
  endfunction

endpackage

// File: rtl/quadrature_decoder_filter.sv
// Two-flop synchroniser followed by a stability filter for one encoder channel.
module input_glitch_filter #(
  parameter int unsigned FILTER_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic filtered,
  output logic valid
);

  logic sync_meta;
  logic sync_out;

  // Bring the asynchronous channel into the clock domain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_meta <= 1'b0;
      sync_out  <= 1'b0;
    end else begin
      sync_meta <= raw;
      sync_out  <= sync_meta;
    end
  end

  if (FILTER_CYCLES == 0) begin : g_bypass
    logic [1:0] fill;

    // Synchroniser output becomes meaningful once both flops hold sampled data.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) fill <= '0;
      else        fill <= {fill[0], 1'b1};
    end

    assign filtered = sync_out;
    assign valid    = fill[1];
  end else begin : g_filter
    localparam int unsigned CW = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(FILTER_CYCLES - 1);

    logic [CW-1:0] stable_cnt;
    logic          filt_q;
    logic          valid_q;

    // Reload on the edge the synchronised value changes (sync_meta differs from
    // sync_out); accept it after FILTER_CYCLES further unchanged edges.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        stable_cnt <= '0;
        filt_q     <= 1'b0;
        valid_q    <= 1'b0;
      end else if (sync_meta != sync_out) begin
        stable_cnt <= '0;
      end else if ((sync_out != filt_q) || !valid_q) begin
        if (stable_cnt == LAST) begin
          filt_q     <= sync_out;
          valid_q    <= 1'b1;
          stable_cnt <= '0;
        end else begin
          stable_cnt <= stable_cnt + 1'b1;
        end
      end else begin
        stable_cnt <= '0;
      end
    end

    assign filtered = filt_q;
    assign valid    = valid_q;
  end

endmodule

// File: rtl/quadrature_decoder.sv
// Quadrature decoder: filtered A/B channels to step pulse, direction and error tracking.
module quadrature_decoder #(
  parameter int unsigned FILTER_CYCLES     = 4,
  parameter int unsigned STEP_MODE         = 4,
  parameter int unsigned ERROR_COUNT_WIDTH = 8
) (
  input  logic                         Clk,
  input  logic                         Reset,
  input  logic                         Enable,
  input  logic                         ChannelA,
  input  logic                         ChannelB,
  input  logic                         ErrorClear,
  output logic                         StepPulse,
  output logic                         UpDownMode,
  output logic                         ErrorFlag,
  output logic [ERROR_COUNT_WIDTH-1:0] ErrorCount
);
  import quadrature_pkg::*;

  if ((STEP_MODE != STEP_MODE_X1) && (STEP_MODE != STEP_MODE_X2) &&
      (STEP_MODE != STEP_MODE_X4)) begin : g_bad_step_mode
    $error("quadrature_decoder: STEP_MODE must be 1, 2 or 4");
  end

  localparam logic [ERROR_COUNT_WIDTH-1:0] COUNT_ONE = ERROR_COUNT_WIDTH'(1);

  logic      filt_a, filt_b;
  logic      valid_a, valid_b;
  ab_state_t sample;
  ab_state_t state_q, state_d;
  logic      primed_q, primed_d;
  logic      step_up, step_down, illegal, qualified;

  input_glitch_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_filter_a (
    .clk      (Clk),
    .rst_n    (Reset),
    .raw      (ChannelA),
    .filtered (filt_a),
    .valid    (valid_a)
  );

  input_glitch_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_filter_b (
    .clk      (Clk),
    .rst_n    (Reset),
    .raw      (ChannelB),
    .filtered (filt_b),
    .valid    (valid_b)
  );

  // Priming and transition classification against the stored state.
  always_comb begin
    sample    = ab_state_t'({filt_a, filt_b});
    state_d   = state_q;
    primed_d  = primed_q;
    step_up   = 1'b0;
    step_down = 1'b0;
    illegal   = 1'b0;
    if (!primed_q) begin
      if (valid_a && valid_b) begin
        state_d  = sample;
        primed_d = 1'b1;
      end
    end else if (sample != state_q) begin
      state_d = sample;
      if (sample == next_up(state_q))        step_up   = 1'b1;
      else if (sample == next_down(state_q)) step_down = 1'b1;
      else                                   illegal   = 1'b1;
    end
  end

  // Decide which legal steps produce a pulse at the configured resolution.
  always_comb begin
    qualified = 1'b0;
    case (STEP_MODE)
      STEP_MODE_X4: qualified = step_up | step_down;
      STEP_MODE_X2: qualified = (step_up | step_down) && (sample[1] != state_q[1]);
      default:      qualified = (step_up && (state_q == ST_00)) ||
                                (step_down && (state_q == ST_10));
    endcase
  end

  // State register plus registered pulse, direction and sticky error outputs.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q    <= ST_00;
      primed_q   <= 1'b0;
      StepPulse  <= 1'b0;
      UpDownMode <= DIR_UP;
      ErrorFlag  <= 1'b0;
      ErrorCount <= '0;
    end else begin
      state_q   <= state_d;
      primed_q  <= primed_d;
      StepPulse <= Enable && qualified;
      if (Enable && qualified) UpDownMode <= step_up ? DIR_UP : DIR_DOWN;
      // An illegal transition outranks a simultaneous clear.
      if (illegal) begin
        ErrorFlag  <= 1'b1;
        ErrorCount <= ErrorClear ? COUNT_ONE
                    : ((&ErrorCount) ? ErrorCount : ErrorCount + 1'b1);
      end else if (ErrorClear) begin
        ErrorFlag  <= 1'b0;
        ErrorCount <= '0;
      end
    end
  end

endmodule

// File: tb/tb_quadrature_decoder.sv
// Scoreboard bench for quadrature_decoder in x4 (default) and x1 step modes.
module tb_quadrature_decoder;

  logic Clk = 1'b0;
  always #5 Clk = ~Clk;

  logic       Reset, Enable, en1, ChannelA, ChannelB, ErrorClear;
  logic       sp0, dir0, ef0, sp1, dir1, ef1;
  logic [7:0] ec0, ec1;

  quadrature_decoder #(.FILTER_CYCLES(4), .STEP_MODE(4), .ERROR_COUNT_WIDTH(8)) dut (
    .Clk(Clk), .Reset(Reset), .Enable(Enable), .ChannelA(ChannelA), .ChannelB(ChannelB),
    .ErrorClear(ErrorClear), .StepPulse(sp0), .UpDownMode(dir0), .ErrorFlag(ef0),
    .ErrorCount(ec0)
  );

  quadrature_decoder #(.FILTER_CYCLES(4), .STEP_MODE(1), .ERROR_COUNT_WIDTH(8)) dut_x1 (
    .Clk(Clk), .Reset(Reset), .Enable(en1), .ChannelA(ChannelA), .ChannelB(ChannelB),
    .ErrorClear(ErrorClear), .StepPulse(sp1), .UpDownMode(dir1), .ErrorFlag(ef1),
    .ErrorCount(ec1)
  );

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   drive_cyc = 0;
  int   pulses0 = 0, pulses1 = 0;
  int   pos0 = 0, pos1 = 0;
  int   last_pulse_cyc0 = 0;
  logic prev0 = 1'b0, prev1 = 1'b0;
  logic q0[$];
  logic q1[$];
  logic [1:0] cur;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [1:0] tb_up(input logic [1:0] s);
    case (s)
      2'b00:   return 2'b10;
      2'b10:   return 2'b11;
      2'b11:   return 2'b01;
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic [1:0] tb_down(input logic [1:0] s);
    case (s)
      2'b00:   return 2'b01;
      2'b01:   return 2'b11;
      2'b11:   return 2'b10;
      default: return 2'b00;
    endcase
  endfunction

  always @(posedge Clk) cyc <= cyc + 1;

  // Pop one expected direction per observed pulse on each DUT.
  always @(negedge Clk) begin
    if (sp0) begin
      pulses0++;
      last_pulse_cyc0 = cyc;
      pos0 += dir0 ? 1 : -1;
      check_eq("x4_pulse_width", prev0, 0);
      check_eq("x4_pulse_expected", q0.size() != 0, 1);
      if (q0.size() != 0) check_eq("x4_direction", dir0, q0.pop_front());
    end
    if (sp1) begin
      pulses1++;
      pos1 += dir1 ? 1 : -1;
      check_eq("x1_pulse_width", prev1, 0);
      check_eq("x1_pulse_expected", q1.size() != 0, 1);
      if (q1.size() != 0) check_eq("x1_direction", dir1, q1.pop_front());
    end
    prev0 = sp0;
    prev1 = sp1;
  end

  task automatic move(input logic up, input int hold);
    logic [1:0] nxt;
    nxt = up ? tb_up(cur) : tb_down(cur);
    @(negedge Clk);
    if (Enable) q0.push_back(up);
    if (en1 && ((up && cur == 2'b00) || (!up && cur == 2'b10))) q1.push_back(up);
    {ChannelA, ChannelB} = nxt;
    cur = nxt;
    drive_cyc = cyc;
    repeat (hold) @(negedge Clk);
  endtask

  task automatic set_ab(input logic [1:0] v, input int hold);
    @(negedge Clk);
    {ChannelA, ChannelB} = v;
    cur = v;
    repeat (hold) @(negedge Clk);
  endtask

  task automatic do_reset(input logic [1:0] v);
    @(negedge Clk);
    Reset = 1'b0;
    {ChannelA, ChannelB} = v;
    cur = v;
    repeat (3) @(negedge Clk);
    Reset = 1'b1;
    repeat (20) @(negedge Clk);
  endtask

  initial begin
    int p0, p1;
    Reset = 1'b0; Enable = 1'b1; en1 = 1'b0; ErrorClear = 1'b0;
    ChannelA = 1'b1; ChannelB = 1'b1; cur = 2'b11;

    // Reset values, then static 11 after priming
    repeat (2) @(negedge Clk);
    check_eq("rst_step", sp0, 0);
    check_eq("rst_dir", dir0, 1);
    check_eq("rst_flag", ef0, 0);
    check_eq("rst_count", ec0, 0);
    Reset = 1'b1;
    repeat (30) @(negedge Clk);
    check_eq("static_pulses", pulses0, 0);
    check_eq("static_flag", ef0, 0);
    check_eq("static_dir", dir0, 1);
    check_eq("static_count", ec0, 0);

    // Eight full up cycles at default settings
    do_reset(2'b00);
    p0 = pulses0; pos0 = 0;
    for (int i = 0; i < 8; i++) begin
      for (int s = 0; s < 4; s++) begin
        move(1'b1, 20);
        if (i == 0 && s == 0) check_eq("first_pulse_latency", last_pulse_cyc0 - drive_cyc, 7);
      end
    end
    repeat (10) @(negedge Clk);
    check_eq("up_pulse_count", pulses0 - p0, 32);
    check_eq("up_counter", pos0, 32);
    check_eq("up_dir", dir0, 1);
    check_eq("up_queue_empty", q0.size(), 0);

    // Five up steps then three down steps
    p0 = pulses0; pos0 = 0;
    for (int i = 0; i < 5; i++) move(1'b1, 20);
    for (int i = 0; i < 3; i++) move(1'b0, 20);
    check_eq("updown_pulse_count", pulses0 - p0, 8);
    check_eq("updown_counter", pos0, 2);
    check_eq("updown_dir", dir0, 0);

    // Glitch rejection, illegal transition, saturation, clear
    do_reset(2'b00);
    p0 = pulses0;
    @(negedge Clk); ChannelA = 1'b1;
    repeat (2) @(negedge Clk); ChannelA = 1'b0;
    repeat (20) @(negedge Clk);
    check_eq("glitch_pulses", pulses0 - p0, 0);
    check_eq("glitch_flag", ef0, 0);
    check_eq("glitch_count", ec0, 0);
    set_ab(2'b11, 20);
    check_eq("illegal_flag", ef0, 1);
    check_eq("illegal_count", ec0, 1);
    check_eq("illegal_pulses", pulses0 - p0, 0);
    check_eq("illegal_dir", dir0, 1);
    for (int i = 0; i < 300; i++) begin
      set_ab(cur ^ 2'b11, 8);
      if (i == 99) check_eq("count_101", ec0, 101);
    end
    check_eq("count_saturated", ec0, 255);
    check_eq("sat_flag", ef0, 1);
    check_eq("sat_pulses", pulses0 - p0, 0);
    @(negedge Clk); ErrorClear = 1'b1;
    @(negedge Clk); ErrorClear = 1'b0;
    check_eq("clear_flag", ef0, 0);
    check_eq("clear_count", ec0, 0);

    // Disabled steps: no pulses, frozen direction, no catch-up
    move(1'b0, 20);
    check_eq("pre_disable_dir", dir0, 0);
    @(negedge Clk); Enable = 1'b0;
    p0 = pulses0;
    for (int i = 0; i < 6; i++) move(1'b1, 20);
    check_eq("disabled_pulses", pulses0 - p0, 0);
    check_eq("disabled_dir_frozen", dir0, 0);
    @(negedge Clk); Enable = 1'b1;
    repeat (20) @(negedge Clk);
    check_eq("catchup_pulses", pulses0 - p0, 0);
    move(1'b1, 20);
    check_eq("reenable_pulses", pulses0 - p0, 1);
    check_eq("reenable_dir", dir0, 1);

    // STEP_MODE=1 instance
    do_reset(2'b00);
    en1 = 1'b1;
    p1 = pulses1;
    for (int i = 0; i < 4; i++) move(1'b1, 20);
    check_eq("x1_cycle_pulses", pulses1 - p1, 1);
    check_eq("x1_cycle_dir", dir1, 1);
    move(1'b1, 20);
    move(1'b0, 20);
    check_eq("x1_down_pulses", pulses1 - p1, 3);
    check_eq("x1_down_dir", dir1, 0);
    set_ab(2'b11, 20);
    check_eq("x1_err_flag", ef1, 1);
    check_eq("x1_err_count", ec1, 1);
    // Asynchronous reset between clock edges
    @(negedge Clk);
    #2 Reset = 1'b0;
    #1;
    check_eq("async_rst_dir", dir1, 1);
    check_eq("async_rst_flag", ef1, 0);
    check_eq("async_rst_count", ec1, 0);
    check_eq("async_rst_step", sp1, 0);
    check_eq("async_rst_count_x4", ec0, 0);
    @(negedge Clk); Reset = 1'b1;
    repeat (20) @(negedge Clk);
    set_ab(2'b00, 20);
    check_eq("x1_err_again", ec1, 1);
    // Clear lands on the same edge as a new illegal transition
    @(negedge Clk); {ChannelA, ChannelB} = 2'b11; cur = 2'b11;
    repeat (6) @(negedge Clk); ErrorClear = 1'b1;
    @(negedge Clk); ErrorClear = 1'b0;
    check_eq("clear_vs_err_count", ec1, 1);
    check_eq("clear_vs_err_flag", ef1, 1);
    check_eq("clear_vs_err_count_x4", ec0, 1);
    repeat (10) @(negedge Clk);
    check_eq("final_q0_empty", q0.size(), 0);
    check_eq("final_q1_empty", q1.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
